pixbuf_pingpong_ctrl: RTL and testbench
=======================================

PIXBUF_PINGPONG_CTRL -- requirements
Module: pixbuf_pingpong_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter DEPTH, default 64, pixels per 8x8 block.
REQ-003 SHALL have parameter PAD_VALUE, default 0, fill value for flush padding.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port pix_data  input  DATA_WIDTH  upstream pixel, raster order within block.
REQ-008 SHALL have port pix_ready  output  1  controller can accept pixel.
REQ-009 SHALL have port flush  input  1  single-cycle pulse; pad and close the partial block.
REQ-010 SHALL have port wr_en_0 / wr_en_1  output  1 each  1-pixel write enable to buffer 0 / 1.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  pixel to both buffers.
REQ-012 SHALL have port blk_valid  output  1  a full block is ready for the consumer.
REQ-013 SHALL have port blk_sel  output  1  index of the full buffer offered.
REQ-014 SHALL have port blk_ack  input  1  consumer has finished with the offered buffer.
REQ-015 SHALL have port blk_cnt  output  16  completed blocks, wraps at 2^16.

Function
REQ-016 SHALL track each buffer as EMPTY, FILL or FULL, with write pointer wr_sel, read pointer rd_sel and a 6-bit pixel counter pix_cnt.
REQ-017 SHALL assert pix_ready when buffer[wr_sel] is not FULL, no pad is in progress and no completion is pending.
REQ-018 SHALL accept a pixel on a rising edge when pix_valid and pix_ready are both high, and move buffer[wr_sel] EMPTY->FILL on its first pixel.
REQ-019 SHALL, for an accepted pixel, drive wr_en_<wr_sel>=1 and wr_data=pix_data, registered, in the following cycle; at most one wr_en is high in any cycle.
REQ-020 SHALL increment pix_cnt per write; the write at pix_cnt=DEPTH-1 wraps pix_cnt to 0, toggles wr_sel and marks the buffer FULL on the edge that ends its wr_en cycle.
REQ-021 SHALL issue exactly DEPTH writes per buffer fill, keeping each buffer's internal sequential write index aligned to 0 at every fill start.
REQ-022 SHALL drive blk_valid=1 when buffer[rd_sel] is FULL, and blk_sel=rd_sel.
REQ-023 SHALL treat blk_ack as valid only while blk_valid=1; then buffer[rd_sel]->EMPTY and rd_sel toggles; blk_ack while blk_valid=0 is ignored.
REQ-024 SHALL increment blk_cnt by 1 per buffer transition to FULL.
REQ-025 SHALL, on flush while buffer[wr_sel] is FILL, enter PAD state: pix_ready=0, one PAD_VALUE write per cycle until pix_cnt wraps, then complete as REQ-020.
REQ-026 SHALL ignore flush when pix_cnt=0 or when PAD is already active.
REQ-027 SHALL process a pixel accepted in the same cycle as flush before padding starts.
REQ-028 SHALL apply completion of one buffer and blk_ack of the other in the same cycle independently; both take effect on that edge.
REQ-029 SHALL hold pix_ready=0 while both buffers are FULL and release it the cycle after the first blk_ack.

Reset
REQ-030 SHALL, with reset_n low, force pix_ready=0, wr_en_0=wr_en_1=0, wr_data=0, blk_valid=0, blk_sel=0, blk_cnt=0, both buffers EMPTY, wr_sel=rd_sel=0, pix_cnt=0, PAD inactive.
REQ-031 SHALL, on reset mid-fill or mid-pad, discard the partial block; the shared reset_n realigns the buffers' write indices.

Structure
REQ-032 SHALL place the buffer-state enum (EMPTY/FILL/FULL) and the default DEPTH/DATA_WIDTH in the shared JPEG encoder package.
REQ-033 SHALL instantiate no sub-modules; the two databuffer_64x8bit instances are placed by the parent, connected via wr_en_x and wr_data.

Verification
REQ-034 SHALL cover: 64 pixels 0..63 back-to-back -> wr_en_0 high for 64 cycles, wr_data 0..63, then blk_valid=1, blk_sel=0, blk_cnt=1.
REQ-035 SHALL cover: 192 pixels, no blk_ack -> pix_ready falls after pixel 128; blk_ack -> blk_sel changes 0 then 1, pixel 129 is written to buffer 0.
REQ-036 SHALL cover: 10 pixels then flush -> pix_ready=0, 54 writes of PAD_VALUE to buffer 0, blk_valid=1, next pixel goes to buffer 1.
REQ-037 SHALL cover: blk_ack for buffer 0 in the same cycle buffer 1 completes -> buffer 0 EMPTY, blk_sel=1, blk_valid stays 1, blk_cnt=2.
REQ-038 SHALL cover: reset_n low after 30 pixels -> all outputs at reset values; 64 new pixels then fill buffer 0 from index 0.
REQ-039 SHALL cover: blk_ack with blk_valid=0 and flush with pix_cnt=0 -> no state change.

Source files
------------

// File: rtl/pixbuf_pingpong_ctrl_pkg.sv
// Shared JPEG encoder definitions: pixel block geometry and ping-pong buffer states.
package pixbuf_pingpong_ctrl_pkg;
  localparam int PIX_DATA_WIDTH = 8;
  localparam int PIX_DEPTH      = 64;
  localparam int BLK_CNT_W      = 16;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;
endpackage

// File: rtl/pixbuf_pingpong_ctrl_if.sv
// Pixel intake, buffer write port and block offer/ack signals of the ping-pong controller.
interface pixbuf_pingpong_ctrl_if
  import pixbuf_pingpong_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_DATA_WIDTH
);
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;
  logic                  flush;
  logic                  wr_en_0;
  logic                  wr_en_1;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  blk_valid;
  logic                  blk_sel;
  logic                  blk_ack;
  logic [BLK_CNT_W-1:0]  blk_cnt;

  modport master (
    output pix_valid, pix_data, flush, blk_ack,
    input  pix_ready, wr_en_0, wr_en_1, wr_data, blk_valid, blk_sel, blk_cnt
  );

  modport slave (
    input  pix_valid, pix_data, flush, blk_ack,
    output pix_ready, wr_en_0, wr_en_1, wr_data, blk_valid, blk_sel, blk_cnt
  );
endinterface

// File: rtl/pixbuf_pingpong_ctrl.sv
// Ping-pong write/offer controller for two block buffers; each write lands the cycle after accept.
// pix_ready drops while the closing write is in flight, while padding, and while the target buffer is FULL.
module pixbuf_pingpong_ctrl
  import pixbuf_pingpong_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = PIX_DATA_WIDTH,
  parameter int                    DEPTH      = PIX_DEPTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input logic                   clock,
  input logic                   reset_n,
  pixbuf_pingpong_ctrl_if.slave bus
);
  localparam int              CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  buf_state_e            r_buf_st [2];
  logic                  r_wr_sel;
  logic                  r_rd_sel;
  logic                  r_pad;
  logic                  r_live;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic                  r_wr_en_0;
  logic                  r_wr_en_1;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [BLK_CNT_W-1:0]  r_blk_cnt;

  logic w_wr_busy;
  logic w_last_inflight;
  logic w_pix_ready;
  logic w_accept;
  logic w_pad_wr;
  logic w_start_pad;
  logic w_blk_valid;
  logic w_ack;

  // pix_cnt counts finished writes; the one in flight is the last when pix_cnt already sits at DEPTH-1
  assign w_wr_busy       = r_wr_en_0 | r_wr_en_1;
  assign w_last_inflight = w_wr_busy && (r_pix_cnt == LAST);
  assign w_pix_ready     = r_live && (r_buf_st[r_wr_sel] != BUF_FULL) && !r_pad && !w_last_inflight;
  assign w_accept        = bus.pix_valid && w_pix_ready;
  assign w_pad_wr        = r_pad && !w_last_inflight;
  assign w_start_pad     = bus.flush && !r_pad && (r_buf_st[r_wr_sel] == BUF_FILL) &&
                           (r_pix_cnt != '0) && !w_last_inflight;
  assign w_blk_valid     = (r_buf_st[r_rd_sel] == BUF_FULL);
  assign w_ack           = bus.blk_ack && w_blk_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_st[0] <= BUF_EMPTY;
      r_buf_st[1] <= BUF_EMPTY;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_pad       <= 1'b0;
      r_live      <= 1'b0;
      r_pix_cnt   <= '0;
      r_wr_en_0   <= 1'b0;
      r_wr_en_1   <= 1'b0;
      r_wr_data   <= '0;
      r_blk_cnt   <= '0;
    end else begin
      r_live    <= 1'b1;
      r_wr_en_0 <= (w_accept || w_pad_wr) && !r_wr_sel;
      r_wr_en_1 <= (w_accept || w_pad_wr) && r_wr_sel;
      if (w_accept) begin
        r_wr_data <= bus.pix_data;
      end else if (w_pad_wr) begin
        r_wr_data <= PAD_VALUE;
      end
      if (w_accept && (r_buf_st[r_wr_sel] == BUF_EMPTY)) begin
        r_buf_st[r_wr_sel] <= BUF_FILL;
      end
      if (w_start_pad) begin
        r_pad <= 1'b1;
      end
      // Completion and ack always target different buffers, so both may land on one edge
      if (w_wr_busy) begin
        if (w_last_inflight) begin
          r_pix_cnt          <= '0;
          r_wr_sel           <= ~r_wr_sel;
          r_buf_st[r_wr_sel] <= BUF_FULL;
          r_blk_cnt          <= r_blk_cnt + BLK_CNT_W'(1);
          r_pad              <= 1'b0;
        end else begin
          r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
      end
      if (w_ack) begin
        r_buf_st[r_rd_sel] <= BUF_EMPTY;
        r_rd_sel           <= ~r_rd_sel;
      end
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.wr_en_0   = r_wr_en_0;
  assign bus.wr_en_1   = r_wr_en_1;
  assign bus.wr_data   = r_wr_data;
  assign bus.blk_valid = w_blk_valid;
  assign bus.blk_sel   = r_rd_sel;
  assign bus.blk_cnt   = r_blk_cnt;
endmodule

// File: tb/tb_pixbuf_pingpong_ctrl.sv
// Bench for the ping-pong controller: queue-based model of block filling, write and ack monitors.
module tb_pixbuf_pingpong_ctrl;
  import pixbuf_pingpong_ctrl_pkg::*;

  localparam int          DW    = 8;
  localparam int          DEPTH = 64;
  localparam logic [DW-1:0] PAD = 8'hA5;

  typedef struct packed {
    logic          sel;
    logic [DW-1:0] dat;
  } wr_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pixbuf_pingpong_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  pixbuf_pingpong_ctrl #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .PAD_VALUE (PAD)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  wr_t  exp_wr_q[$];
  logic exp_blk_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_n;
  logic m_fb;
  int   m_blks;
  bit   ack_auto = 1'b0;
  int   ack_rate = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels fill the current buffer in order; DEPTH of them close it
  task automatic m_pix(input logic [DW-1:0] d);
    wr_t e;
    e.sel = m_fb;
    e.dat = d;
    exp_wr_q.push_back(e);
    m_n++;
    if (m_n == DEPTH) begin
      m_n = 0;
      exp_blk_q.push_back(m_fb);
      m_fb = ~m_fb;
      m_blks++;
    end
  endtask

  task automatic m_flush();
    int k;
    k = DEPTH - m_n;
    if (m_n != 0) repeat (k) m_pix(PAD);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.flush     = 1'b0;
    bus.blk_ack   = 1'b0;
    reset_n       = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_wr_en", 32'({bus.wr_en_1, bus.wr_en_0}), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
    check("rst_blk_sel", 32'(bus.blk_sel), 32'd0);
    check("rst_blk_cnt", 32'(bus.blk_cnt), 32'd0);
    exp_wr_q.delete();
    exp_blk_q.delete();
    m_n    = 0;
    m_fb   = 1'b0;
    m_blks = 0;
    step();
    reset_n = 1'b1;
    step();
    step();
  endtask

  // Caller is aligned 1 time unit after a rising edge; returns aligned the same way
  task automatic send_pix(input logic [DW-1:0] d);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (bus.pix_ready) break;
      if (t >= 400) begin
        check("ready_timeout", 32'(bus.pix_ready), 32'd1);
        step();
        bus.pix_valid = 1'b0;
        return;
      end
      step();
    end
    m_pix(d);
    step();
    bus.pix_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.blk_ack = 1'b1;
    step();
    bus.blk_ack = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 500; t++) begin
      @(negedge clock);
      if (exp_wr_q.size() == 0) break;
    end
    if (t == 500) check("drain_timeout", 32'(exp_wr_q.size()), 32'd0);
    step();
    step();
  endtask

  // Monitor: every write and every accepted ack is matched against the model queues
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.wr_en_0 || bus.wr_en_1) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 32'({bus.wr_en_1, bus.wr_en_0}), 32'd0);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_en_sel", 32'({bus.wr_en_1, bus.wr_en_0}), e.sel ? 32'd2 : 32'd1);
            check("wr_data", 32'(bus.wr_data), 32'(e.dat));
          end
        end
        if (bus.blk_ack && bus.blk_valid) begin
          if (exp_blk_q.size() == 0) check("unexpected_blk_offer", 32'(bus.blk_valid), 32'd0);
          else check("blk_sel_on_ack", 32'(bus.blk_sel), 32'(exp_blk_q.pop_front()));
        end
      end
    end
  end

  initial begin : auto_ack
    forever begin
      @(posedge clock);
      #1;
      if (ack_auto) bus.blk_ack = ($urandom_range(99) < ack_rate);
    end
  end

  initial begin : main
    int t0;
    int hi;
    int t;

    do_reset();

    // One full block back to back
    t0 = cyc;
    for (int i = 0; i < 64; i++) send_pix(8'(i));
    check("b2b_cycles", 32'(cyc - t0), 32'd64);
    wait_drain();
    @(negedge clock);
    check("blk1_valid", 32'(bus.blk_valid), 32'd1);
    check("blk1_sel", 32'(bus.blk_sel), 32'd0);
    check("blk1_cnt", 32'(bus.blk_cnt), 32'd1);
    step();

    // Both buffers full stall pixel intake until the first ack
    do_reset();
    for (int i = 0; i < 128; i++) send_pix(8'(i));
    hi = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'd128;
    repeat (8) begin
      @(negedge clock);
      if (bus.pix_ready) hi++;
    end
    check("ready_both_full", 32'(hi), 32'd0);
    check("both_full_sel", 32'(bus.blk_sel), 32'd0);
    check("both_full_cnt", 32'(bus.blk_cnt), 32'd2);
    step();
    bus.pix_valid = 1'b0;
    ack_pulse();
    @(negedge clock);
    check("ready_after_ack", 32'(bus.pix_ready), 32'd1);
    check("sel_after_ack", 32'(bus.blk_sel), 32'd1);
    step();
    for (int i = 128; i < 192; i++) send_pix(8'(i));
    wait_drain();
    @(negedge clock);
    check("blk3_cnt", 32'(bus.blk_cnt), 32'd3);
    step();
    ack_pulse();
    ack_pulse();
    @(negedge clock);
    check("all_acked_valid", 32'(bus.blk_valid), 32'd0);
    step();

    // Flush after ten pixels pads the rest of buffer 0
    do_reset();
    for (int i = 0; i < 10; i++) send_pix(8'(i + 100));
    bus.flush = 1'b1;
    @(negedge clock);
    m_flush();
    step();
    bus.flush = 1'b0;
    @(negedge clock);
    check("ready_during_pad", 32'(bus.pix_ready), 32'd0);
    step();
    wait_drain();
    @(negedge clock);
    check("pad_blk_valid", 32'(bus.blk_valid), 32'd1);
    check("pad_blk_sel", 32'(bus.blk_sel), 32'd0);
    check("pad_blk_cnt", 32'(bus.blk_cnt), 32'd1);
    step();
    send_pix(8'h3C);
    wait_drain();

    // Ack of buffer 0 on the very edge buffer 1 completes
    do_reset();
    for (int i = 0; i < 128; i++) send_pix(8'(i ^ 8'h5A));
    bus.blk_ack = 1'b1;
    step();
    bus.blk_ack = 1'b0;
    @(negedge clock);
    check("same_edge_valid", 32'(bus.blk_valid), 32'd1);
    check("same_edge_sel", 32'(bus.blk_sel), 32'd1);
    check("same_edge_cnt", 32'(bus.blk_cnt), 32'd2);
    check("same_edge_ready", 32'(bus.pix_ready), 32'd1);
    step();
    ack_pulse();
    @(negedge clock);
    check("same_edge_drained", 32'(bus.blk_valid), 32'd0);
    step();

    // Reset mid-fill discards the partial block
    do_reset();
    for (int i = 0; i < 30; i++) send_pix(8'(i + 7));
    do_reset();
    for (int i = 0; i < 64; i++) send_pix(8'(255 - i));
    wait_drain();
    @(negedge clock);
    check("post_rst_valid", 32'(bus.blk_valid), 32'd1);
    check("post_rst_sel", 32'(bus.blk_sel), 32'd0);
    check("post_rst_cnt", 32'(bus.blk_cnt), 32'd1);
    step();

    // Flush with nothing pending is a no-op
    bus.flush = 1'b1;
    @(negedge clock);
    m_flush();
    step();
    bus.flush = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("idle_flush_cnt", 32'(bus.blk_cnt), 32'd1);
    check("idle_flush_ready", 32'(bus.pix_ready), 32'd1);
    check("idle_flush_sel", 32'(bus.blk_sel), 32'd0);
    step();

    // Ack with nothing offered is ignored
    do_reset();
    ack_pulse();
    step();
    @(negedge clock);
    check("stray_ack_valid", 32'(bus.blk_valid), 32'd0);
    check("stray_ack_sel", 32'(bus.blk_sel), 32'd0);
    step();
    for (int i = 0; i < 64; i++) send_pix(8'(i * 3));
    wait_drain();
    @(negedge clock);
    check("stray_ack_blk_sel", 32'(bus.blk_sel), 32'd0);
    check("stray_ack_blk_valid", 32'(bus.blk_valid), 32'd1);
    step();

    // Randomized traffic with random acks and legal flushes
    do_reset();
    ack_rate = 30;
    ack_auto = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic          v;
      logic [DW-1:0] d;
      logic          f;
      v = ($urandom_range(3) != 0);
      d = 8'($urandom);
      f = ((m_n >= 2) || (m_n == 0 && !v)) && ($urandom_range(39) == 0);
      bus.pix_valid = v;
      bus.pix_data  = d;
      bus.flush     = f;
      @(negedge clock);
      if (v && bus.pix_ready) m_pix(d);
      if (f) m_flush();
      step();
    end
    bus.pix_valid = 1'b0;
    bus.flush     = 1'b0;
    ack_rate      = 100;
    for (t = 0; t < 2000; t++) begin
      @(negedge clock);
      if (exp_wr_q.size() == 0 && exp_blk_q.size() == 0) break;
    end
    if (t == 2000) check("rand_drain_timeout", 32'(exp_blk_q.size()), 32'd0);
    step();
    ack_auto = 1'b0;
    step();
    bus.blk_ack = 1'b0;
    step();
    step();
    @(negedge clock);
    check("rand_blk_cnt", 32'(bus.blk_cnt), 32'(m_blks[15:0]));
    check("rand_blk_valid", 32'(bus.blk_valid), 32'd0);
    check("rand_leftover_wr", 32'(exp_wr_q.size()), 32'd0);
    check("rand_leftover_blk", 32'(exp_blk_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
